// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter controller.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BR   = 3'd1,
    JMP  = 3'd2,
    ERET = 3'd3,
    EXC  = 3'd4,
    HOLD = 3'd5
  } pc_src_e;

  localparam int unsigned DEF_WIDTH       = 32'd32;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC     = 32'h0000_4180;
  localparam int unsigned DEF_STEP        = 32'd4;
  localparam int unsigned DEF_BOOT_CYCLES = 32'd1;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 32'd1) ? $clog2(v) : 32'd1;
  endfunction

endpackage

// File: rtl/pc_boot_timer.sv
// Boot hold timer: counts down the remaining boot cycles and flags completion.
module pc_boot_timer
  import pc_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = DEF_BOOT_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned   CW   = clog2_min1(BOOT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(BOOT_CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done while the last boot cycle is in progress, so the FSM leaves BOOT on that edge.
  assign done_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: boot hold, prioritised redirect selection, EPC and halt.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      STEP        = DEF_STEP,
  parameter int unsigned      BOOT_CYCLES = DEF_BOOT_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_pc_i,
  input  logic             eret_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0] addr_next_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             valid_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 32'd1);

  pc_state_e        state_q, state_d;
  pc_src_e          src;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] target;
  logic             target_bad;
  logic             boot_done;

  pc_boot_timer #(
    .BOOT_CYCLES(BOOT_CYCLES)
  ) u_boot_timer (
    .CLK   (CLK),
    .RST   (RST),
    .en_i  (state_q == BOOT),
    .done_o(boot_done)
  );

  // Exceptions bypass the stall; in HALT only an exception is heard.
  always_comb begin
    src     = HOLD;
    state_d = state_q;
    case (state_q)
      BOOT: begin
        if (boot_done) begin
          state_d = RUN;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (exc_i) begin
          src = EXC;
        end else if (!EN) begin
          src = HOLD;
        end else if (halt_i) begin
          src     = HOLD;
          state_d = HALT;
        end else if (eret_i) begin
          src = ERET;
        end else if (jmp_i) begin
          src = JMP;
        end else if (br_taken_i) begin
          src = BR;
        end else begin
          src = SEQ;
        end
      end
      HALT: begin
        if (exc_i) begin
          src     = EXC;
          state_d = RUN;
        end else begin
          src = HOLD;
        end
      end
      default: begin
        src     = HOLD;
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    target     = addr_q;
    addr_d     = addr_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    case (src)
      ERET:    target = epc_q;
      JMP:     target = jmp_target_i;
      BR:      target = br_target_i;
      default: target = addr_q;
    endcase
    target_bad = ((target & ALIGN_MASK) != {WIDTH{1'b0}});
    case (src)
      SEQ: addr_d = addr_q + STEP_W;
      BR, JMP, ERET: begin
        // A misaligned redirect traps instead, recording where it came from.
        if (target_bad) begin
          addr_d     = EXC_VEC;
          epc_d      = addr_q;
          misalign_d = 1'b1;
        end else begin
          addr_d = target;
        end
      end
      EXC: begin
        addr_d = EXC_VEC;
        epc_d  = exc_pc_i;
      end
      HOLD:    addr_d = addr_q;
      default: addr_d = addr_q;
    endcase
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= BOOT;
      addr_q     <= RESET_VEC;
      epc_q      <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      epc_q      <= epc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign addr_o      = addr_q;
  assign addr_next_o = addr_q + STEP_W;
  assign epc_o       = epc_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomised and directed bench for pc_ctrl against a behavioural reference model.
module tb_pc_ctrl;

  localparam int unsigned BC  = 3;
  localparam int unsigned STP = 4;
  localparam logic [31:0] RV  = 32'h0000_3000;
  localparam logic [31:0] EV  = 32'h0000_4180;

  logic        CLK = 1'b0;
  logic        RST, EN, br_taken_i, jmp_i, exc_i, eret_i, halt_i;
  logic [31:0] br_target_i, jmp_target_i, exc_pc_i;
  logic [31:0] addr_o, addr_next_o, epc_o;
  logic        valid_o, misalign_o;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_on = 1'b0;

  logic [31:0] m_addr, m_epc;
  logic        m_valid, m_mis;
  int          m_boot_left;
  bit          m_halted;

  pc_ctrl #(
    .WIDTH(32), .RESET_VEC(RV), .EXC_VEC(EV), .STEP(STP), .BOOT_CYCLES(BC)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
    .exc_i(exc_i), .exc_pc_i(exc_pc_i),
    .eret_i(eret_i), .halt_i(halt_i),
    .addr_o(addr_o), .addr_next_o(addr_next_o), .epc_o(epc_o),
    .valid_o(valid_o), .misalign_o(misalign_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the PC must be after each edge, from the rules directly.
  task automatic model_step();
    logic [31:0] t;
    bit          redirect;
    if (RST) begin
      m_addr = RV; m_epc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
      m_boot_left = BC; m_halted = 1'b0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
      m_mis = 1'b0;
      m_valid = (m_boot_left == 0);
    end else if (m_halted) begin
      m_mis = 1'b0;
      if (exc_i) begin
        m_addr = EV; m_epc = exc_pc_i; m_halted = 1'b0; m_valid = 1'b1;
      end
    end else begin
      m_mis = 1'b0;
      m_valid = 1'b1;
      if (exc_i) begin
        m_addr = EV; m_epc = exc_pc_i;
      end else if (EN) begin
        if (halt_i) begin
          m_halted = 1'b1; m_valid = 1'b0;
        end else begin
          redirect = 1'b1;
          t = 32'h0;
          if (eret_i) t = m_epc;
          else if (jmp_i) t = jmp_target_i;
          else if (br_taken_i) t = br_target_i;
          else redirect = 1'b0;
          if (!redirect) m_addr = 32'(m_addr + STP);
          else if ((t % STP) != 0) begin
            m_epc = m_addr; m_addr = EV; m_mis = 1'b1;
          end else m_addr = t;
        end
      end
    end
  endtask

  always @(posedge CLK) model_step();

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("addr_o", addr_o, m_addr);
      chk("addr_next_o", addr_next_o, 32'(m_addr + STP));
      chk("epc_o", epc_o, m_epc);
      chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
      chk("misalign_o", {31'd0, misalign_o}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear();
    br_taken_i = 1'b0; jmp_i = 1'b0; exc_i = 1'b0; eret_i = 1'b0; halt_i = 1'b0;
    br_target_i = 32'h0; jmp_target_i = 32'h0; exc_pc_i = 32'h0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FF00 | (r & 32'hFF);
    if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
    return r;
  endfunction

  initial begin
    RST = 1'b1; EN = 1'b1; clear();
    step(); chk_on = 1'b1;
    step();
    chk("rst addr", addr_o, 32'h3000);
    chk("rst valid", {31'd0, valid_o}, 32'd0);
    chk("rst epc", epc_o, 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("boot addr", addr_o, 32'h3000);
      chk("boot valid", {31'd0, valid_o}, 32'd0);
    end
    step(); chk("boot exit valid", {31'd0, valid_o}, 32'd1); chk("boot exit addr", addr_o, 32'h3000);
    step(); chk("seq1", addr_o, 32'h3004);
    step(); chk("seq2", addr_o, 32'h3008);
    step(); step(); chk("seq4", addr_o, 32'h3010);
    br_taken_i = 1'b1; br_target_i = 32'h3100; jmp_i = 1'b1; jmp_target_i = 32'h3200;
    step(); chk("jmp over br", addr_o, 32'h3200);
    clear(); step(); chk("after jmp", addr_o, 32'h3204);
    EN = 1'b0; jmp_i = 1'b1; jmp_target_i = 32'h3300;
    for (int i = 0; i < 4; i++) begin
      step(); chk("stall hold", addr_o, 32'h3204);
    end
    EN = 1'b1; step(); chk("stall release", addr_o, 32'h3300);
    jmp_target_i = 32'h3020; step(); chk("jmp 3020", addr_o, 32'h3020);
    clear(); EN = 1'b0; exc_i = 1'b1; exc_pc_i = 32'h301C;
    step(); chk("exc addr", addr_o, 32'h4180); chk("exc epc", epc_o, 32'h301C);
    clear(); EN = 1'b1; step(); chk("handler seq", addr_o, 32'h4184);
    eret_i = 1'b1; step(); chk("eret", addr_o, 32'h301C);
    clear(); jmp_i = 1'b1; jmp_target_i = 32'h3040; step(); chk("jmp 3040", addr_o, 32'h3040);
    jmp_target_i = 32'h3102; step();
    chk("misalign addr", addr_o, 32'h4180); chk("misalign epc", epc_o, 32'h3040);
    chk("misalign pulse", {31'd0, misalign_o}, 32'd1);
    clear(); step(); chk("misalign drop", {31'd0, misalign_o}, 32'd0); chk("post trap", addr_o, 32'h4184);
    halt_i = 1'b1; step(); chk("halt addr", addr_o, 32'h4184); chk("halt valid", {31'd0, valid_o}, 32'd0);
    clear(); br_taken_i = 1'b1; br_target_i = 32'h3100; jmp_i = 1'b1; jmp_target_i = 32'h3200;
    step(); EN = 1'b0; step(); EN = 1'b1;
    chk("halt ignores", addr_o, 32'h4184); chk("halt valid2", {31'd0, valid_o}, 32'd0);
    clear(); exc_i = 1'b1; exc_pc_i = 32'h3333; step();
    chk("halt exc addr", addr_o, 32'h4180); chk("halt exc valid", {31'd0, valid_o}, 32'd1);
    chk("halt exc epc", epc_o, 32'h3333);
    clear(); halt_i = 1'b1; step();
    clear(); RST = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h5000; step();
    chk("rst in halt addr", addr_o, 32'h3000); chk("rst in halt epc", epc_o, 32'h0);
    RST = 1'b0; clear();
    for (int i = 0; i < 3; i++) step();
    chk("reboot valid", {31'd0, valid_o}, 32'd1);
    jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC; step();
    chk("top addr", addr_o, 32'hFFFF_FFFC); chk("top next", addr_next_o, 32'h0);
    clear(); step(); chk("wrap", addr_o, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      RST          = ($urandom_range(0, 99) == 0);
      EN           = ($urandom_range(0, 3) != 0);
      exc_i        = ($urandom_range(0, 15) == 0);
      halt_i       = ($urandom_range(0, 19) == 0);
      eret_i       = ($urandom_range(0, 7) == 0);
      jmp_i        = ($urandom_range(0, 5) == 0);
      br_taken_i   = ($urandom_range(0, 4) == 0);
      br_target_i  = rand_target();
      jmp_target_i = rand_target();
      exc_pc_i     = rand_target();
      step();
    end
    clear(); RST = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
